// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: MEM->WB pipeline boundary register.
// Carries LANES register-file write ports and the HI/LO write port.
// Two-entry (main + skid) buffer keeps in_ready registered, so upstream
// stalls never form a combinational path through this stage.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. A producer holding valid high keeps its payload stable until
// ready is seen. out_* stay stable while out_valid=1 and out_ready=0.
// All out_* payload reads as zero whenever out_valid=0.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ADDR_W-1:0]   in_wreg_addr,
  input  logic [LANES-1:0]          in_wreg_en,
  input  logic [LANES*DATA_W-1:0]   in_wreg_data,
  input  logic [DATA_W-1:0]         in_hi,
  input  logic [DATA_W-1:0]         in_lo,
  input  logic                      in_whilo,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ADDR_W-1:0]   out_wreg_addr,
  output logic [LANES-1:0]          out_wreg_en,
  output logic [LANES*DATA_W-1:0]   out_wreg_data,
  output logic [DATA_W-1:0]         out_hi,
  output logic [DATA_W-1:0]         out_lo,
  output logic                      out_whilo,
  output logic [CNT_W-1:0]          stall_count,
  output logic [1:0]                dbg_state
);

  localparam int PW = LANES*ADDR_W + LANES + LANES*DATA_W + 2*DATA_W + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_in_ready;
  logic [PW-1:0]     r_main;
  logic [PW-1:0]     r_skid;
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_out_valid;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic [LANES-1:0]  w_in_en;
  logic [PW-1:0]     w_in_payload;

  logic [LANES*ADDR_W-1:0] w_m_addr;
  logic [LANES-1:0]        w_m_en;
  logic [LANES*DATA_W-1:0] w_m_data;
  logic [DATA_W-1:0]       w_m_hi;
  logic [DATA_W-1:0]       w_m_lo;
  logic                    w_m_whilo;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // Writes to register 0 are dropped at capture by clearing the lane enable.
  always_comb begin
    w_in_en = '0;
    for (int i = 0; i < LANES; i++) begin
      w_in_en[i] = in_wreg_en[i] & (in_wreg_addr[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  assign w_in_payload = {in_wreg_addr, w_in_en, in_wreg_data, in_hi, in_lo, in_whilo};

  // Next-state and entry-load decisions; flush overrides every transition.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_next   = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_next = S_FULL;
          w_load_skid  = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          w_state_next     = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_next     = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // State register; in_ready is registered as "skid will be empty".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != S_FULL);
    end
  end

  // Entry storage: main drives the outputs, skid absorbs one stalled entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_payload;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_payload;
      end
    end
  end

  // Saturating count of cycles where WB holds back a valid entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign {w_m_addr, w_m_en, w_m_data, w_m_hi, w_m_lo, w_m_whilo} = r_main;

  assign in_ready      = r_in_ready;
  assign out_valid     = w_out_valid;
  assign out_wreg_addr = w_out_valid ? w_m_addr  : '0;
  assign out_wreg_en   = w_out_valid ? w_m_en    : '0;
  assign out_wreg_data = w_out_valid ? w_m_data  : '0;
  assign out_hi        = w_out_valid ? w_m_hi    : '0;
  assign out_lo        = w_out_valid ? w_m_lo    : '0;
  assign out_whilo     = w_out_valid ? w_m_whilo : 1'b0;
  assign stall_count   = r_stall_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg with two lanes and a 4-bit stall counter.
module tb_wb_pipe_reg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LANES  = 2;
  localparam int CNT_W  = 4;

  logic                    clock;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*ADDR_W-1:0] in_wreg_addr;
  logic [LANES-1:0]        in_wreg_en;
  logic [LANES*DATA_W-1:0] in_wreg_data;
  logic [DATA_W-1:0]       in_hi;
  logic [DATA_W-1:0]       in_lo;
  logic                    in_whilo;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ADDR_W-1:0] out_wreg_addr;
  logic [LANES-1:0]        out_wreg_en;
  logic [LANES*DATA_W-1:0] out_wreg_data;
  logic [DATA_W-1:0]       out_hi;
  logic [DATA_W-1:0]       out_lo;
  logic                    out_whilo;
  logic [CNT_W-1:0]        stall_count;
  logic [1:0]              dbg_state;

  int checks = 0;
  int errors = 0;

  wb_pipe_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg_addr(in_wreg_addr), .in_wreg_en(in_wreg_en),
    .in_wreg_data(in_wreg_data), .in_hi(in_hi), .in_lo(in_lo),
    .in_whilo(in_whilo), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wreg_addr(out_wreg_addr), .out_wreg_en(out_wreg_en),
    .out_wreg_data(out_wreg_data), .out_hi(out_hi), .out_lo(out_lo),
    .out_whilo(out_whilo), .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Lane 0 / lane 1 address, enable, data plus HI/LO port.
  task automatic drive(input logic v,
                       input logic [4:0] a0, input logic e0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic e1, input logic [31:0] d1,
                       input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    in_valid     = v;
    in_wreg_addr = {a1, a0};
    in_wreg_en   = {e1, e0};
    in_wreg_data = {d1, d0};
    in_hi        = hi;
    in_lo        = lo;
    in_whilo     = whilo;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_addr"},  64'(out_wreg_addr), 64'd0);
    chk({tag, "_en"},    64'(out_wreg_en), 64'd0);
    chk({tag, "_data"},  64'(out_wreg_data), 64'd0);
    chk({tag, "_hi"},    64'(out_hi), 64'd0);
    chk({tag, "_lo"},    64'(out_lo), 64'd0);
    chk({tag, "_whilo"}, 64'(out_whilo), 64'd0);
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    chk_nop("rst");
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_count), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    tick();

    // Basic passthrough
    drive(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 5'd3, 1'b0, 32'h1111, 32'hAAAA, 32'hBBBB, 1'b1);
    tick();
    chk("pt_valid", 64'(out_valid), 64'd1);
    chk("pt_addr", 64'(out_wreg_addr), 64'h65);
    chk("pt_en", 64'(out_wreg_en), 64'd1);
    chk("pt_data", 64'(out_wreg_data), 64'h00001111_DEADBEEF);
    chk("pt_hi", 64'(out_hi), 64'hAAAA);
    chk("pt_lo", 64'(out_lo), 64'hBBBB);
    chk("pt_whilo", 64'(out_whilo), 64'd1);
    idle();
    tick();
    chk_nop("pt_drain");

    // Register-0 write suppression
    drive(1'b1, 5'd0, 1'b1, 32'h12345678, 5'd31, 1'b1, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("z_en", 64'(out_wreg_en), 64'h2);
    chk("z_addr", 64'(out_wreg_addr), 64'h3E0);
    chk("z_data", 64'(out_wreg_data), 64'h9ABCDEF0_12345678);
    idle();
    tick();
    chk("z_drain", 64'(out_valid), 64'd0);

    // Skid fill: A then B with WB stalled, C held upstream
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'hA0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("sk_a_valid", 64'(out_valid), 64'd1);
    chk("sk_a_ready", 64'(in_ready), 64'd1);
    chk("sk_a_stall", 64'(stall_count), 64'd0);
    drive(1'b1, 5'd2, 1'b1, 32'hB0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("sk_b_ready", 64'(in_ready), 64'd0);
    chk("sk_b_state", 64'(dbg_state), 64'd2);
    chk("sk_b_data", 64'(out_wreg_data), 64'hA0);
    chk("sk_b_stall", 64'(stall_count), 64'd1);
    drive(1'b1, 5'd3, 1'b1, 32'hC0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("sk_c1_ready", 64'(in_ready), 64'd0);
    chk("sk_c1_data", 64'(out_wreg_data), 64'hA0);
    chk("sk_c1_stall", 64'(stall_count), 64'd2);
    tick();
    chk("sk_c2_stall", 64'(stall_count), 64'd3);
    out_ready = 1'b1;
    #1;
    chk("sk_out_a", 64'(out_wreg_data), 64'hA0);
    tick();
    chk("sk_out_b_valid", 64'(out_valid), 64'd1);
    chk("sk_out_b", 64'(out_wreg_data), 64'hB0);
    chk("sk_out_b_addr", 64'(out_wreg_addr), 64'd2);
    chk("sk_out_b_ready", 64'(in_ready), 64'd1);
    tick();
    chk("sk_out_c_valid", 64'(out_valid), 64'd1);
    chk("sk_out_c", 64'(out_wreg_data), 64'hC0);
    idle();
    tick();
    chk("sk_drain", 64'(out_valid), 64'd0);
    chk("sk_stall_hold", 64'(stall_count), 64'd3);

    // Flush in FULL with a new entry offered
    out_ready = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 32'h44, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 32'h55, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("fl_full", 64'(dbg_state), 64'd2);
    chk("fl_stall_pre", 64'(stall_count), 64'd4);
    flush = 1'b1;
    drive(1'b1, 5'd6, 1'b1, 32'h66, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_data", 64'(out_wreg_data), 64'd0);
    chk("fl_stall", 64'(stall_count), 64'd5);
    flush = 1'b0;
    idle();
    tick();
    chk("fl_no_c", 64'(out_valid), 64'd0);

    // Flush in ONE while a new entry fires: the new entry is discarded
    out_ready = 1'b1;
    drive(1'b1, 5'd7, 1'b1, 32'h77, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 5'd8, 1'b1, 32'h88, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("fl1_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    idle();
    tick();
    chk("fl1_no_new", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 32'h99, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 32'hAA, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("ar_full", 64'(dbg_state), 64'd2);
    chk("ar_stall_pre", 64'(stall_count), 64'd6);
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk_nop("ar");
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_stall", 64'(stall_count), 64'd0);
    chk("ar_state", 64'(dbg_state), 64'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("ar_after", 64'(out_valid), 64'd0);

    // Counter saturation at 15 with CNT_W=4
    drive(1'b1, 5'd11, 1'b1, 32'hBB, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 64'(stall_count), 64'd15);
    chk("sat_hold_data", 64'(out_wreg_data), 64'hBB);
    out_ready = 1'b1;
    tick();
    chk("sat_drain", 64'(out_valid), 64'd0);
    chk("sat_keep", 64'(stall_count), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
